// File: rtl/input_feature_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// input_feature_fetch_sequencer
//
// Walks one input-feature batch (channel, then row, then column innermost)
// and issues BRAM reads at linear addresses 0..N-1. The one-cycle BRAM read
// latency is absorbed by an in-flight stage that carries the pixel's
// coordinate tags. Landed data goes into a 2-entry FIFO, which presents a
// valid/ready pixel stream. A read is issued only when the FIFO plus the
// in-flight slot has room for it, so the FIFO can never overflow.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_start + i_num_channel/i_start_row/i_end_row/i_num_col
//                           start pulse and batch configuration (sampled in IDLE)
//   o_busy, o_done          batch in progress / one-cycle completion pulse
//   o_bram_en, o_bram_addr  BRAM read request
//   i_bram_rdata            BRAM read data, valid the cycle after o_bram_en
//   o_data, o_channel, o_row, o_col, o_valid, i_ready
//                           tagged pixel stream towards the convolution datapath
// ---------------------------------------------------------------------------
module input_feature_fetch_sequencer #(
    parameter int INPUT_CHANNEL_WIDTH    = 8,
    parameter int INPUT_ROW_WIDTH        = 6,
    parameter int INPUT_COL_WIDTH        = 6,
    parameter int DATA_WIDTH             = 8,
    parameter int INPUT_BRAM_DEPTH       = 224 * 244,
    parameter int INPUT_BRAM_DEPTH_WIDTH = $clog2(INPUT_BRAM_DEPTH)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [INPUT_CHANNEL_WIDTH-1:0]    i_num_channel,
    input  logic [INPUT_ROW_WIDTH-1:0]        i_start_row,
    input  logic [INPUT_ROW_WIDTH-1:0]        i_end_row,
    input  logic [INPUT_COL_WIDTH-1:0]        i_num_col,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_bram_en,
    output logic [INPUT_BRAM_DEPTH_WIDTH-1:0] o_bram_addr,
    input  logic [DATA_WIDTH-1:0]             i_bram_rdata,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [INPUT_CHANNEL_WIDTH-1:0]    o_channel,
    output logic [INPUT_ROW_WIDTH-1:0]        o_row,
    output logic [INPUT_COL_WIDTH-1:0]        o_col,
    output logic                              o_valid,
    input  logic                              i_ready
);

    localparam int ENTRY_W = DATA_WIDTH + INPUT_CHANNEL_WIDTH + INPUT_ROW_WIDTH + INPUT_COL_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [INPUT_CHANNEL_WIDTH-1:0]      num_ch_q, num_ch_d;
    logic [INPUT_ROW_WIDTH-1:0]          start_row_q, start_row_d;
    logic [INPUT_ROW_WIDTH-1:0]          end_row_q, end_row_d;
    logic [INPUT_COL_WIDTH-1:0]          num_col_q, num_col_d;
    logic [INPUT_CHANNEL_WIDTH-1:0]      ch_q, ch_d;
    logic [INPUT_ROW_WIDTH-1:0]          row_q, row_d;
    logic [INPUT_COL_WIDTH-1:0]          col_q, col_d;
    logic [INPUT_BRAM_DEPTH_WIDTH-1:0]   addr_q, addr_d;
    logic                                inflight_q, inflight_d;
    logic [INPUT_CHANNEL_WIDTH-1:0]      inf_ch_q, inf_ch_d;
    logic [INPUT_ROW_WIDTH-1:0]          inf_row_q, inf_row_d;
    logic [INPUT_COL_WIDTH-1:0]          inf_col_q, inf_col_d;
    logic [ENTRY_W-1:0]                  fifo_q [2];
    logic [ENTRY_W-1:0]                  fifo_d [2];
    logic                                wr_ptr_q, wr_ptr_d;
    logic                                rd_ptr_q, rd_ptr_d;
    logic [1:0]                          count_q, count_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;

    logic                                push_s;
    logic                                pop_s;
    logic [2:0]                          occ_s;
    logic                                issue_s;
    logic                                last_col_s;
    logic                                last_row_s;
    logic                                last_ch_s;
    logic                                empty_cfg_s;

    // Handshake, credit check and scan-boundary decodes.
    always_comb begin
        push_s      = inflight_q;
        pop_s       = (count_q != 2'd0) && i_ready;
        // Occupancy after this cycle's pop; a slot freed by a pop is reusable at once.
        occ_s       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s     = (state_q == ST_RUN) && (occ_s < 3'd2);
        last_col_s  = (col_q == (num_col_q - INPUT_COL_WIDTH'(1)));
        last_row_s  = (row_q == end_row_q);
        last_ch_s   = (ch_q == (num_ch_q - INPUT_CHANNEL_WIDTH'(1)));
        empty_cfg_s = (i_num_channel == '0) || (i_num_col == '0) || (i_end_row < i_start_row);
    end

    // Output FIFO: push landed BRAM data with its tags, pop on handshake.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = {i_bram_rdata, inf_ch_q, inf_row_q, inf_col_q};
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Batch FSM, raster counters and the tag stage that rides with each read.
    always_comb begin
        state_d     = state_q;
        num_ch_d    = num_ch_q;
        start_row_d = start_row_q;
        end_row_d   = end_row_q;
        num_col_d   = num_col_q;
        ch_d        = ch_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        inflight_d  = issue_s;
        inf_ch_d    = issue_s ? ch_q  : inf_ch_q;
        inf_row_d   = issue_s ? row_q : inf_row_q;
        inf_col_d   = issue_s ? col_q : inf_col_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_ch_d    = i_num_channel;
                    start_row_d = i_start_row;
                    end_row_d   = i_end_row;
                    num_col_d   = i_num_col;
                    ch_d        = '0;
                    row_d       = i_start_row;
                    col_d       = '0;
                    addr_d      = '0;
                    state_d     = empty_cfg_s ? ST_FINISH : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    addr_d = addr_q + INPUT_BRAM_DEPTH_WIDTH'(1);
                    if (!last_col_s) begin
                        col_d = col_q + INPUT_COL_WIDTH'(1);
                    end else begin
                        col_d = '0;
                        if (!last_row_s) begin
                            row_d = row_q + INPUT_ROW_WIDTH'(1);
                        end else begin
                            row_d = start_row_q;
                            ch_d  = ch_q + INPUT_CHANNEL_WIDTH'(1);
                            if (last_ch_s) begin
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final pop is happening so o_done lands one cycle after it.
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // o_busy and o_done fall/rise together on the cycle after FINISH.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FINISH);
    end

    // State, configuration, counters, in-flight stage and FIFO registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            num_ch_q    <= '0;
            start_row_q <= '0;
            end_row_q   <= '0;
            num_col_q   <= '0;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            inf_ch_q    <= '0;
            inf_row_q   <= '0;
            inf_col_q   <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            start_row_q <= start_row_d;
            end_row_q   <= end_row_d;
            num_col_q   <= num_col_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            inf_ch_q    <= inf_ch_d;
            inf_row_q   <= inf_row_d;
            inf_col_q   <= inf_col_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_bram_en   = issue_s;
    assign o_bram_addr = addr_q;
    assign o_valid     = (count_q != 2'd0);
    assign {o_data, o_channel, o_row, o_col} = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_input_feature_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for input_feature_fetch_sequencer. A random-content BRAM model answers
// reads one cycle later. Each batch's expected address list and tagged pixel
// list come from nested loops over channel/row/column with the address
// computed by the closed-form formula; a negedge monitor pops and compares.
// Timing: cyc counts rising edges; "start edge" S is the edge sampling i_start.
// ---------------------------------------------------------------------------
module tb_input_feature_fetch_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] ch;
        logic [5:0] r;
        logic [5:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_num_channel;
    logic [5:0]  i_start_row, i_end_row, i_num_col;
    logic        o_busy, o_done, o_bram_en, o_valid, i_ready;
    logic [15:0] o_bram_addr;
    logic [7:0]  bram_rdata, o_data, o_channel;
    logic [5:0]  o_row, o_col;

    logic [7:0]  mem [256];
    pix_t        exp_q [$];
    logic [15:0] addr_q [$];

    int total = 0, bad = 0;
    int cyc = 0;
    int reads = 0, pops = 0, done_cnt = 0;
    int exp_done = -1, fv_edge = 0, rmode = 0, pidx = 0;
    bit fv_pending = 1'b0, held_v = 1'b0;
    pix_t held_pix;

    input_feature_fetch_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
        .i_num_channel(i_num_channel), .i_start_row(i_start_row),
        .i_end_row(i_end_row), .i_num_col(i_num_col),
        .o_busy(o_busy), .o_done(o_done), .o_bram_en(o_bram_en),
        .o_bram_addr(o_bram_addr), .i_bram_rdata(bram_rdata),
        .o_data(o_data), .o_channel(o_channel), .o_row(o_row), .o_col(o_col),
        .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read BRAM model.
    always @(posedge clk) if (o_bram_en) bram_rdata <= mem[o_bram_addr[7:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: i_ready = 1'b1;
                1: i_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            pidx++;
        end
    end

    // Monitor: reads, pixels, stall stability, outstanding bound, done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_bram_en) begin
                reads++;
                if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                else check("bram_addr", o_bram_addr, addr_q.pop_front());
            end
            if (o_valid) begin
                if (fv_pending) begin
                    check("first_valid_latency", cyc, fv_edge);
                    fv_pending = 1'b0;
                end
                if (held_v) check("stall_hold", {o_data, o_channel, o_row, o_col}, held_pix);
                if (i_ready) begin
                    pops++;
                    if (exp_q.size() == 0) check("unexpected_pixel", 1, 0);
                    else begin
                        check("pixel", {o_data, o_channel, o_row, o_col}, exp_q.pop_front());
                        // Handshake at edge cyc+1, o_done visible after edge cyc+2.
                        if (exp_q.size() == 0) exp_done = cyc + 2;
                    end
                end
            end
            held_v   = o_valid && !i_ready;
            held_pix = {o_data, o_channel, o_row, o_col};
            if (o_busy) check("outstanding_le_2", ((reads - pops) <= 2) ? 1 : 0, 1);
            if (o_done) begin
                done_cnt++;
                check("done_timing", cyc, exp_done);
                check("busy_low_at_done", o_busy, 0);
                check("done_all_consumed", exp_q.size() + addr_q.size(), 0);
            end
        end
    end

    task automatic wait_done();
        int d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
        check("single_done", done_cnt, d0 + 1);
        check("busy_low_after", o_busy, 0);
    endtask

    task automatic run_batch(input int nch, input int sr, input int er, input int ncol,
                             input bit inject, input bit wait_it);
        bit empty_b = (nch == 0) || (ncol == 0) || (er < sr);
        int rows = er - sr + 1;
        int reads0;
        if (!empty_b) begin
            for (int ch = 0; ch < nch; ch++)
                for (int r = sr; r <= er; r++)
                    for (int c = 0; c < ncol; c++) begin
                        int a = ch * rows * ncol + (r - sr) * ncol + c;
                        pix_t p;
                        p.d = mem[a % 256]; p.ch = 8'(ch); p.r = 6'(r); p.c = 6'(c);
                        addr_q.push_back(16'(a));
                        exp_q.push_back(p);
                    end
        end
        reads0 = reads;
        @(posedge clk); #1;
        i_start = 1'b1; i_num_channel = 8'(nch); i_start_row = 6'(sr);
        i_end_row = 6'(er); i_num_col = 6'(ncol);
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        if (empty_b) exp_done = cyc + 1;
        else begin
            exp_done = -1;
            fv_edge = cyc + 2;
            fv_pending = 1'b1;
        end
        if (inject) begin
            repeat (3) @(posedge clk); #1;
            i_start = 1'b1; i_num_channel = 8'd3; i_start_row = 6'd1;
            i_end_row = 6'd2; i_num_col = 6'd5;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        if (wait_it) begin
            wait_done();
            if (empty_b) check("empty_no_read", reads, reads0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; i_start = 1'b0; i_num_channel = 8'd0;
        i_start_row = 6'd0; i_end_row = 6'd0; i_num_col = 6'd0;
        #12;
        check("reset_state", {o_busy, o_done, o_valid, o_bram_en, o_bram_addr,
                              o_data, o_channel, o_row, o_col}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic, backpressure, empty variants, single pixel.
        rmode = 0; run_batch(2, 3, 4, 3, 1'b0, 1'b1);
        rmode = 1; run_batch(2, 3, 4, 3, 1'b0, 1'b1);
        rmode = 0; run_batch(0, 3, 4, 3, 1'b0, 1'b1);
        run_batch(2, 3, 4, 0, 1'b0, 1'b1);
        run_batch(2, 5, 2, 3, 1'b0, 1'b1);
        run_batch(1, 7, 7, 1, 1'b0, 1'b1);
        rmode = 2; run_batch(1, 7, 7, 1, 1'b0, 1'b1);

        // Start while busy is ignored.
        rmode = 0; run_batch(2, 3, 4, 3, 1'b1, 1'b1);
        rmode = 1; run_batch(1, 0, 1, 4, 1'b1, 1'b1);

        // Randomised batches with random backpressure.
        rmode = 2;
        for (int t = 0; t < 10; t++) begin
            int sr = $urandom_range(0, 20);
            run_batch($urandom_range(1, 3), sr, sr + $urandom_range(0, 2),
                      $urandom_range(1, 6), 1'b0, 1'b1);
        end

        // Reset mid-run after 5 pixels, then a clean batch.
        rmode = 0;
        pops = 0; reads = 0;
        run_batch(2, 3, 4, 3, 1'b0, 1'b0);
        for (int i = 0; i < 200 && pops < 5; i++) @(posedge clk);
        check("reset_test_5_pixels", (pops >= 5) ? 1 : 0, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {o_busy, o_done, o_valid, o_bram_en, o_bram_addr,
                                      o_data, o_channel, o_row, o_col}, 64'd0);
        exp_q.delete(); addr_q.delete();
        fv_pending = 1'b0; held_v = 1'b0; reads = 0; pops = 0; exp_done = -1;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        run_batch(1, 0, 0, 4, 1'b0, 1'b1);
        check("reset_batch_reads", reads, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/input_feature_fetch_sequencer.md
Name: input_feature_fetch_sequencer

Overview:
Upstream stage of the input BRAM address decoder. Walks one input-feature batch (channel × batch-row × column) in raster order and issues BRAM reads. Absorbs the 1-cycle BRAM read latency and delivers a valid/ready pixel stream with coordinate tags to the convolution datapath. Downstream backpressure is handled by a 2-entry output buffer with credit-based read issue.

Parameters:
INPUT_CHANNEL_WIDTH, 8, width of channel index/count
INPUT_ROW_WIDTH, 6, width of row index
INPUT_COL_WIDTH, 6, width of column index/count
DATA_WIDTH, 8, BRAM word / pixel width
INPUT_BRAM_DEPTH, 224*244, input BRAM words
INPUT_BRAM_DEPTH_WIDTH, $clog2(INPUT_BRAM_DEPTH), BRAM address width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; configuration sampled this cycle
i_num_channel  in  INPUT_CHANNEL_WIDTH  channels in batch
i_start_row  in  INPUT_ROW_WIDTH  first feature row of batch
i_end_row  in  INPUT_ROW_WIDTH  last feature row of batch (inclusive)
i_num_col  in  INPUT_COL_WIDTH  columns per row
o_busy  out  1  high from accepted start until done
o_done  out  1  1-cycle pulse after last pixel handshake
o_bram_en  out  1  BRAM read enable
o_bram_addr  out  INPUT_BRAM_DEPTH_WIDTH  BRAM read address
i_bram_rdata  in  DATA_WIDTH  BRAM data, valid 1 cycle after o_bram_en
o_data  out  DATA_WIDTH  pixel
o_channel  out  INPUT_CHANNEL_WIDTH  pixel channel tag
o_row  out  INPUT_ROW_WIDTH  pixel absolute row tag
o_col  out  INPUT_COL_WIDTH  pixel column tag
o_valid  out  1  pixel valid
i_ready  in  1  downstream ready

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State IDLE, counters 0, buffer empty, in-flight flag 0.
- FSM:
  - IDLE: on i_start, latch config, clear counters and address, assert o_busy.
    - If any dimension is empty (i_num_channel==0, i_num_col==0, or i_end_row<i_start_row), go to FINISH. No reads are issued.
    - Otherwise go to RUN.
  - RUN: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the in-flight read lands and the buffer empties, then go to FINISH.
  - FINISH: o_done=1 for one cycle, o_busy falls the same cycle, return to IDLE.
- i_start outside IDLE is ignored. Latched config does not change mid-batch.
- Scan order: column innermost, then row (i_start_row..i_end_row), then channel.
- Address: o_bram_addr = ch*rows*cols + (row-i_start_row)*cols + col, where rows = end-start+1. This equals a linear counter 0..N-1 and is implemented as an incrementing counter, not multipliers. Width is INPUT_BRAM_DEPTH_WIDTH, truncated, no saturation.
- Read issue: o_bram_en=1 in RUN only when buffer_count + inflight < 2, counting a pop in the same cycle as freeing a slot. Tags travel in a 1-stage pipeline alongside the read.
- Data capture: the cycle after o_bram_en, i_bram_rdata and its tags are pushed into the 2-entry FIFO.
- Output: o_valid = FIFO not empty; o_data/o_channel/o_row/o_col show the FIFO head.
  - Pop on o_valid && i_ready.
  - o_data/tags hold stable while o_valid && !i_ready.
- Throughput: 1 pixel/cycle sustained with i_ready held high. First o_valid appears 2 cycles after the start cycle (cycle S+1 read, S+2 valid).
- Simultaneous push and pop on a full FIFO is impossible by the credit rule. Push and pop on a non-empty FIFO keep the count.
- Asynchronous reset mid-batch aborts immediately: state IDLE, FIFO flushed, no o_done. The next i_start begins cleanly.

Test Plan:
- Basic: start with ch=2, rows 3..4, cols=3, i_ready=1 → 12 reads, addr 0..11 consecutive. Tags (0,3,0)…(1,4,2). First o_valid at S+2, o_done at the cycle after the 12th handshake.
- Backpressure: same config, i_ready toggled 1,0,0,1 repeating → no pixel lost or duplicated. o_data stable while stalled. At most 2 buffered plus 0 in flight when stalled. Same 12 values in order.
- Empty batch: ch=0, or cols=0, or end_row=2 with start_row=5 → o_bram_en never asserts, o_done pulses at S+1, o_busy low afterwards.
- Start while busy: second i_start mid-batch with different config → ignored; output matches first config only.
- Reset mid-run: assert i_rst_n=0 after 5 pixels → all outputs 0 asynchronously. New start with ch=1, rows 0..0, cols=4 yields addr 0..3 and one o_done.
- Single pixel: ch=1, rows 7..7, cols=1 → one read at addr 0, tags (0,7,0), o_done one cycle after the handshake.
